// File: rtl/text_ram_server.sv
// text_ram_server: character-cell buffer behind the text renderer.
// One RAM port serves pipelined renderer reads (2-cycle latency). The other RAM port
// is shared by terminal cell writes and a clear engine. The clear engine implements
// scroll-up (a circular row pointer plus a line clear) and full-screen clear.
module text_ram_server #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CELL_W = 32,
    parameter logic [CELL_W-1:0] FILL_CELL = 32'h0000_0020,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic              rd_valid,
    output logic [CELL_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              scroll_up,
    input  logic              clear_all,
    output logic              busy,
    output logic              wr_drop
);

    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = $clog2(CELLS);

    // Constants at the widths they are compared against.
    localparam logic [ROW_W:0]    ROWS_E   = (ROW_W+1)'(ROWS);
    localparam logic [COL_W:0]    COLS_E   = (COL_W+1)'(COLS);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    // Logical row + top is below 2*ROWS, so one conditional subtract replaces a modulo.
    function automatic logic [ADDR_W-1:0] map_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] top
    );
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_E) begin
            sum = sum - ROWS_E;
        end
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    logic [CELL_W-1:0] mem [0:CELLS-1];

    state_t            r_state, w_state_next;
    logic [ROW_W-1:0]  r_top, w_top_next;
    logic [ROW_W-1:0]  r_line, w_line_next;
    logic [ROW_W-1:0]  r_pending, w_pending_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt_next;
    logic [ROW_W-1:0]  w_top_inc;
    logic              r_busy;
    logic              r_wr_drop;

    logic              w_a_we;
    logic [ADDR_W-1:0] w_a_addr;
    logic [CELL_W-1:0] w_a_data;
    logic              w_wr_oor;
    logic              w_wr_drop;

    logic              w_rd_oor;
    logic              r_rd_v1;
    logic              r_rd_oor1;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic              r_rd_valid;
    logic              r_rd_oor2;
    logic [CELL_W-1:0] r_rd_ram;

    assign w_top_inc = (r_top == ROW_LAST) ? '0 : r_top + 1'b1;
    assign w_wr_oor  = ({1'b0, wr_row} >= ROWS_E) || ({1'b0, wr_col} >= COLS_E);
    assign w_rd_oor  = ({1'b0, rd_row} >= ROWS_E) || ({1'b0, rd_col} >= COLS_E);

    // Clear-engine next state: clear_all always wins; scrolls queue up while busy.
    always_comb begin
        w_state_next   = r_state;
        w_top_next     = r_top;
        w_line_next    = r_line;
        w_pending_next = r_pending;
        w_cnt_next     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_all) begin
                    w_state_next   = S_CLR_ALL;
                    w_top_next     = '0;
                    w_cnt_next     = '0;
                    w_pending_next = '0;
                end else if (scroll_up || (r_pending != '0)) begin
                    w_state_next = S_CLR_LINE;
                    w_line_next  = r_top;
                    w_top_next   = w_top_inc;
                    w_cnt_next   = '0;
                    if (!scroll_up) begin
                        w_pending_next = r_pending - 1'b1;
                    end
                end
            end
            S_CLR_LINE: begin
                if (clear_all) begin
                    w_state_next   = S_CLR_ALL;
                    w_top_next     = '0;
                    w_cnt_next     = '0;
                    w_pending_next = '0;
                end else begin
                    if (scroll_up && (r_pending != ROW_LAST)) begin
                        w_pending_next = r_pending + 1'b1;
                    end
                    if (r_cnt == LAST_COL) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_CLR_ALL: begin
                if (clear_all) begin
                    w_top_next     = '0;
                    w_cnt_next     = '0;
                    w_pending_next = '0;
                end else begin
                    if (scroll_up && (r_pending != ROW_LAST)) begin
                        w_pending_next = r_pending + 1'b1;
                    end
                    if (r_cnt == LAST_ALL) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Port A arbitration: the clear engine owns the port whenever it is not idle.
    always_comb begin
        w_a_we    = 1'b0;
        w_a_addr  = '0;
        w_a_data  = FILL_CELL;
        w_wr_drop = wr_en && ((r_state != S_IDLE) || w_wr_oor);
        case (r_state)
            S_CLR_LINE: begin
                w_a_we   = 1'b1;
                w_a_addr = ADDR_W'(r_line) * ADDR_W'(COLS) + r_cnt;
            end
            S_CLR_ALL: begin
                w_a_we   = 1'b1;
                w_a_addr = r_cnt;
            end
            default: begin
                w_a_we   = wr_en && !w_wr_oor;
                w_a_addr = map_addr(wr_row, wr_col, r_top);
                w_a_data = wr_data;
            end
        endcase
    end

    // Control registers; reset starts a full clear because RAM contents are unknown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLR_ALL;
            r_top     <= '0;
            r_line    <= '0;
            r_pending <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_top     <= w_top_next;
            r_line    <= w_line_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_wr_drop <= w_wr_drop;
        end
    end

    // RAM port A write (user cells and clear engine).
    always_ff @(posedge clk) begin
        if (w_a_we) begin
            mem[w_a_addr] <= w_a_data;
        end
    end

    // Read pipeline stage 1: map the logical address with the current top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_oor1  <= 1'b0;
            r_rd_addr1 <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oor2  <= 1'b0;
        end else begin
            r_rd_v1    <= rd_req;
            r_rd_oor1  <= w_rd_oor;
            r_rd_addr1 <= w_rd_oor ? '0 : map_addr(rd_row, rd_col, r_top);
            r_rd_valid <= r_rd_v1;
            r_rd_oor2  <= r_rd_oor1;
        end
    end

    // RAM port B registered read; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        r_rd_ram <= mem[r_rd_addr1];
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = !r_rd_valid ? '0 : (r_rd_oor2 ? FILL_CELL : r_rd_ram);
    assign busy     = r_busy;
    assign wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_text_ram_server.sv
// Directed bench for text_ram_server: reset clear, reads/writes, scroll, clears, drops.
module tb_text_ram_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rd_row;
    logic [6:0]  rd_col;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [6:0]  wr_col;
    logic [31:0] wr_data;
    logic        scroll_up;
    logic        clear_all;
    logic        busy;
    logic        wr_drop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    text_ram_server dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .scroll_up (scroll_up),
        .clear_all (clear_all),
        .busy      (busy),
        .wr_drop   (wr_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input string tag, input int row, input int col, input logic [31:0] exp);
        rd_req = 1'b1;
        rd_row = 5'(row);
        rd_col = 7'(col);
        tick();
        rd_req = 1'b0;
        check({tag, "/early"}, 32'(rd_valid), 32'd0);
        tick();
        check({tag, "/valid"}, 32'(rd_valid), 32'd1);
        check({tag, "/data"}, rd_data, exp);
    endtask

    task automatic write_cell(input string tag, input int row, input int col,
                              input logic [31:0] data, input logic exp_drop);
        wr_en   = 1'b1;
        wr_row  = 5'(row);
        wr_col  = 7'(col);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        check({tag, "/drop"}, 32'(wr_drop), 32'(exp_drop));
        tick();
        check({tag, "/drop_end"}, 32'(wr_drop), 32'd0);
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        check(tag, n, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        int quiet;
        int n;
        logic [31:0] exp_b2b [4];

        rst = 1'b1; rd_req = 1'b0; rd_row = '0; rd_col = '0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        scroll_up = 1'b0; clear_all = 1'b0;

        // Test 1: reset values and the power-on clear.
        repeat (3) tick();
        check("rst/busy", 32'(busy), 32'd1);
        check("rst/rd_valid", 32'(rd_valid), 32'd0);
        check("rst/rd_data", rd_data, 32'd0);
        check("rst/wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b0;
        count_busy("t1/busy_cycles", 2400);
        read_cell("t1/r0c0", 0, 0, 32'h20);
        read_cell("t1/r29c79", 29, 79, 32'h20);

        // Test 2: write then read; four back-to-back reads.
        write_cell("t2/w35", 3, 5, 32'hA5, 1'b0);
        read_cell("t2/r35", 3, 5, 32'hA5);
        write_cell("t2/w70", 7, 0, 32'h70, 1'b0);
        write_cell("t2/w71", 7, 1, 32'h71, 1'b0);
        exp_b2b[0] = 32'hA5; exp_b2b[1] = 32'h70; exp_b2b[2] = 32'h71; exp_b2b[3] = 32'h20;
        for (int i = 0; i < 6; i++) begin
            rd_req = (i < 4);
            case (i)
                0: begin rd_row = 5'd3; rd_col = 7'd5; end
                1: begin rd_row = 5'd7; rd_col = 7'd0; end
                2: begin rd_row = 5'd7; rd_col = 7'd1; end
                default: begin rd_row = 5'd0; rd_col = 7'd0; end
            endcase
            tick();
            if (i == 0) begin
                check("t2/b2b_early", 32'(rd_valid), 32'd0);
            end else if (i <= 4) begin
                check($sformatf("t2/b2b%0d_valid", i - 1), 32'(rd_valid), 32'd1);
                check($sformatf("t2/b2b%0d_data", i - 1), rd_data, exp_b2b[i - 1]);
            end else begin
                check("t2/b2b_after", 32'(rd_valid), 32'd0);
            end
        end
        rd_req = 1'b0;

        // Test 3: scroll one line (top 0 -> 1).
        write_cell("t3/w10", 1, 0, 32'h11, 1'b0);
        scroll_up = 1'b1;
        tick();
        scroll_up = 1'b0;
        count_busy("t3/busy_cycles", 80);
        read_cell("t3/r00", 0, 0, 32'h11);
        read_cell("t3/r29c0", 29, 0, 32'h20);
        read_cell("t3/r60", 6, 0, 32'h70);

        // Test 5: write with scroll in the same cycle, writes while busy and out of range.
        wr_en = 1'b1; wr_row = 5'd4; wr_col = 7'd4; wr_data = 32'h44;
        scroll_up = 1'b1;
        tick();
        wr_en = 1'b0; scroll_up = 1'b0;
        check("t5/sim_drop", 32'(wr_drop), 32'd0);
        check("t5/sim_busy", 32'(busy), 32'd1);
        wr_en = 1'b1; wr_row = 5'd0; wr_col = 7'd0; wr_data = 32'hCC;
        tick();
        wr_en = 1'b0;
        check("t5/busy_drop", 32'(wr_drop), 32'd1);
        tick();
        check("t5/busy_drop_end", 32'(wr_drop), 32'd0);
        count_busy("t5/busy_rest", 78);
        read_cell("t5/r34", 3, 4, 32'h44);
        read_cell("t5/r15", 1, 5, 32'hA5);
        read_cell("t5/r00", 0, 0, 32'h20);
        write_cell("t5/w_row30", 30, 0, 32'hDD, 1'b1);
        write_cell("t5/w_col80", 0, 80, 32'hDE, 1'b1);
        read_cell("t5/r00_after", 0, 0, 32'h20);
        read_cell("t5/r10_after", 1, 0, 32'h20);
        read_cell("t5/r_oor_row", 31, 0, 32'h20);
        read_cell("t5/r_oor_col", 5, 127, 32'h20);

        // Test 4: thirty back-to-back scrolls clear every line exactly once.
        write_cell("t4/w57", 5, 7, 32'h57, 1'b0);
        read_cell("t4/r57_pre", 5, 7, 32'h57);
        high = 0;
        for (int i = 0; i < 30; i++) begin
            scroll_up = 1'b1;
            tick();
            if (busy) high++;
        end
        scroll_up = 1'b0;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 4000) begin
            tick();
            n++;
            if (busy) begin
                high++;
                quiet = 0;
            end else begin
                quiet++;
            end
        end
        check("t4/busy_cycles", high, 2400);
        read_cell("t4/r57", 5, 7, 32'h20);
        read_cell("t4/r34", 3, 4, 32'h20);

        // Test 6: clear_all aborts a line clear and drops pending scrolls.
        scroll_up = 1'b1;
        repeat (3) tick();
        scroll_up = 1'b0;
        repeat (10) tick();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("t6/busy_start", 32'(busy), 32'd1);
        count_busy("t6/busy_cycles", 2400);
        repeat (3) tick();
        check("t6/no_pending", 32'(busy), 32'd0);

        // clear_all and scroll_up together: the scroll is discarded.
        clear_all = 1'b1;
        scroll_up = 1'b1;
        tick();
        clear_all = 1'b0;
        scroll_up = 1'b0;
        count_busy("t6/clr_scroll_cycles", 2400);
        repeat (3) tick();
        check("t6/scroll_dropped", 32'(busy), 32'd0);

        // Reset in the middle of a full clear restarts it from address 0.
        write_cell("t6/w00", 0, 0, 32'h99, 1'b0);
        read_cell("t6/r00", 0, 0, 32'h99);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("t6/rst_busy", 32'(busy), 32'd1);
        check("t6/rst_rd_valid", 32'(rd_valid), 32'd0);
        check("t6/rst_wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b0;
        count_busy("t6/restart_cycles", 2400);
        read_cell("t6/r00_cleared", 0, 0, 32'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
